// File: rtl/i2c_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_cfg_pkg
// Description : Shared state encodings, phase constants and sizing helper for
//               the I2C configuration sequencer and its write engine.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_cfg_pkg;

    // Top-level table-walk states
    typedef logic [2:0] top_state_t;
    localparam top_state_t IDLE  = 3'd0;
    localparam top_state_t LOAD  = 3'd1;
    localparam top_state_t XFER  = 3'd2;
    localparam top_state_t CHECK = 3'd3;
    localparam top_state_t NEXT  = 3'd4;
    localparam top_state_t DONE  = 3'd5;
    localparam top_state_t FAIL  = 3'd6;

    // Write-engine bit-level states
    typedef logic [2:0] eng_state_t;
    localparam eng_state_t E_IDLE  = 3'd0;
    localparam eng_state_t E_START = 3'd1;
    localparam eng_state_t E_BIT   = 3'd2;
    localparam eng_state_t E_ACK   = 3'd3;
    localparam eng_state_t E_STOP  = 3'd4;
    localparam eng_state_t E_GAP   = 3'd5;

    // Quarter-bit phases; SCL is high in the two phases with bit 1 set
    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;
    localparam logic [1:0] P3 = 2'd3;

    // Index width that stays legal for a single-entry table
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_cfg_sequencer_engine.sv
`default_nettype none
// ============================================================================
// Module      : i2c_write_engine
// Description : One I2C write transaction: START, FRAME bytes with ACK check
//               (early STOP on NACK), STOP and one idle bit. Timing comes from
//               a quarter-bit clock-enable derived from the system clock.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_write_engine
    import i2c_cfg_pkg::*;
#(
    parameter int Q           = 625,
    parameter int FRAME_BYTES = 3
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iGo,
    input  logic [8*FRAME_BYTES-1:0] iPayload,
    input  logic [2:0]               iNbytes,
    input  logic                     iSda,
    output logic                     oScl,
    output logic                     oSdaLow,
    output logic                     oEnd,
    output logic                     oNack
);

    localparam int c_QW = (Q > 1) ? $clog2(Q) : 1;
    localparam logic [c_QW-1:0] c_QLAST = c_QW'(Q - 1);
    localparam int c_FW = 8 * FRAME_BYTES;

    logic [c_QW-1:0] r_div;
    logic            w_qtick;
    eng_state_t      r_state;
    logic [1:0]      r_phase;
    logic [2:0]      r_bitCnt;
    logic [2:0]      r_byteCnt;
    logic [c_FW-1:0] r_shift;
    logic            r_nack;
    logic            r_end;
    logic            r_scl;
    logic            r_sdaLow;
    logic            w_scl;
    logic            w_sdaLow;

    assign w_qtick = (r_div == c_QLAST);

    // Quarter-bit divider plus start/bit/ACK/stop sequencing
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_div     <= '0;
            r_state   <= E_IDLE;
            r_phase   <= P0;
            r_bitCnt  <= 3'd0;
            r_byteCnt <= 3'd0;
            r_shift   <= '0;
            r_nack    <= 1'b0;
            r_end     <= 1'b0;
        end else begin
            r_end <= 1'b0;
            r_div <= w_qtick ? '0 : r_div + 1'b1;
            if (r_state == E_IDLE) begin
                if (iGo) begin
                    // Restart the divider so every bit is exactly 4*Q clocks
                    r_state <= E_START;
                    r_phase <= P0;
                    r_div   <= '0;
                    r_shift <= iPayload;
                    r_nack  <= 1'b0;
                end
            end else if (w_qtick) begin
                r_phase <= r_phase + 2'd1;
                if (r_state == E_ACK && r_phase == P2) begin
                    r_nack <= iSda;
                end
                if (r_phase == P3) begin
                    case (r_state)
                        E_START: begin
                            r_state   <= E_BIT;
                            r_bitCnt  <= 3'd0;
                            r_byteCnt <= 3'd0;
                        end
                        E_BIT: begin
                            r_shift <= {r_shift[c_FW-2:0], 1'b0};
                            if (r_bitCnt == 3'd7) begin
                                r_state <= E_ACK;
                            end else begin
                                r_bitCnt <= r_bitCnt + 3'd1;
                            end
                        end
                        E_ACK: begin
                            if (r_nack || r_byteCnt == iNbytes) begin
                                r_state <= E_STOP;
                            end else begin
                                r_state   <= E_BIT;
                                r_bitCnt  <= 3'd0;
                                r_byteCnt <= r_byteCnt + 3'd1;
                            end
                        end
                        E_STOP: r_state <= E_GAP;
                        E_GAP: begin
                            r_state <= E_IDLE;
                            r_end   <= 1'b1;
                        end
                        default: r_state <= E_IDLE;
                    endcase
                end
            end
        end
    end

    // Line levels decoded from state and phase; SCL high in P2/P3
    always_comb begin
        w_scl    = 1'b1;
        w_sdaLow = 1'b0;
        case (r_state)
            E_START: w_sdaLow = r_phase[1];
            E_BIT: begin
                w_scl    = r_phase[1];
                w_sdaLow = ~r_shift[c_FW-1];
            end
            E_ACK:   w_scl = r_phase[1];
            E_STOP: begin
                w_scl    = r_phase[1];
                w_sdaLow = (r_phase != P3);
            end
            default: ;
        endcase
    end

    // Register the line levels so the pads never see decode glitches
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_scl    <= 1'b1;
            r_sdaLow <= 1'b0;
        end else begin
            r_scl    <= w_scl;
            r_sdaLow <= w_sdaLow;
        end
    end

    assign oScl    = r_scl;
    assign oSdaLow = r_sdaLow;
    assign oEnd    = r_end;
    assign oNack   = r_nack;

endmodule
`default_nettype wire

// File: rtl/i2c_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : i2c_cfg_sequencer
// Description : Write-only I2C configuration master. Walks an external table
//               of LUT_SIZE entries, sending each as SLAVE_ADDR + NUM_BYTES
//               payload bytes, with NACK retry and done/error status.
//               Optional macro I2C_CFG_RETRY_CNT_EN adds oRETRY_TOTAL, a
//               saturating count of retries since the last start.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_cfg_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter int         CLK_FREQ   = 50000000,
    parameter int         I2C_FREQ   = 20000,
    parameter int         LUT_SIZE   = 11,
    parameter int         NUM_BYTES  = 2,
    parameter logic [7:0] SLAVE_ADDR = 8'h34,
    parameter int         MAX_RETRY  = 3,
    parameter int         AUTO_START = 1,
    localparam int        IDX_W      = idxWidth(LUT_SIZE)
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic                   iSTART,
    output logic [IDX_W-1:0]       oLUT_INDEX,
    input  logic [8*NUM_BYTES-1:0] iLUT_DATA,
    output logic                   I2C_SCLK,
    inout  wire                    I2C_SDAT,
`ifdef I2C_CFG_RETRY_CNT_EN
    output logic [7:0]             oRETRY_TOTAL,
`endif
    output logic                   oBUSY,
    output logic                   oDONE,
    output logic                   oERROR,
    output logic [IDX_W-1:0]       oERR_INDEX
);

    localparam int c_Q           = CLK_FREQ / (4 * I2C_FREQ);
    localparam int c_FRAME_BYTES = 1 + NUM_BYTES;
    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(LUT_SIZE - 1);
    localparam logic [3:0]       c_MAXR = 4'(MAX_RETRY);

    top_state_t                  r_state;
    logic [IDX_W-1:0]            r_index;
    logic [IDX_W-1:0]            r_errIdx;
    logic [8*c_FRAME_BYTES-1:0]  r_frame;
    logic [3:0]                  r_retry;
    logic                        r_go;
    logic                        r_kick;
    logic                        r_done;
    logic                        r_error;
    logic                        w_sdaLow;
    logic                        w_end;
    logic                        w_nack;
    logic                        w_startReq;
    logic                        w_retry;

    // A start request only counts while idle; busy-time pulses are dropped
    assign w_startReq = (r_state == IDLE) && (iSTART || r_kick);
    assign w_retry    = (r_state == CHECK) && w_nack && (r_retry < c_MAXR);

    i2c_write_engine #(
        .Q           (c_Q),
        .FRAME_BYTES (c_FRAME_BYTES)
    ) u_engine (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iGo      (r_go),
        .iPayload (r_frame),
        .iNbytes  (3'(NUM_BYTES)),
        .iSda     (I2C_SDAT),
        .oScl     (I2C_SCLK),
        .oSdaLow  (w_sdaLow),
        .oEnd     (w_end),
        .oNack    (w_nack)
    );

    assign I2C_SDAT = w_sdaLow ? 1'b0 : 1'bz;

    // Table walk, retry decision and sticky status
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state  <= IDLE;
            r_index  <= '0;
            r_errIdx <= '0;
            r_frame  <= '0;
            r_retry  <= 4'd0;
            r_go     <= 1'b0;
            r_kick   <= (AUTO_START != 0);
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_go <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_startReq) begin
                        r_kick  <= 1'b0;
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                        r_index <= '0;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_frame <= {SLAVE_ADDR, iLUT_DATA};
                    r_retry <= 4'd0;
                    r_go    <= 1'b1;
                    r_state <= XFER;
                end
                XFER: begin
                    if (w_end) begin
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (!w_nack) begin
                        r_state <= NEXT;
                    end else if (w_retry) begin
                        r_retry <= r_retry + 4'd1;
                        r_go    <= 1'b1;
                        r_state <= XFER;
                    end else begin
                        r_state <= FAIL;
                    end
                end
                NEXT: begin
                    if (r_index == c_LAST) begin
                        r_state <= DONE;
                    end else begin
                        r_index <= r_index + 1'b1;
                        r_state <= LOAD;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                FAIL: begin
                    r_error  <= 1'b1;
                    r_errIdx <= r_index;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef I2C_CFG_RETRY_CNT_EN
    logic [7:0] r_retryTotal;

    // Saturating retry tally, cleared whenever a new run begins
    always_ff @(posedge iCLK) begin
        if (iRST || w_startReq) begin
            r_retryTotal <= 8'd0;
        end else if (w_retry && r_retryTotal != 8'hFF) begin
            r_retryTotal <= r_retryTotal + 8'd1;
        end
    end

    assign oRETRY_TOTAL = r_retryTotal;
`endif

    assign oLUT_INDEX = r_index;
    assign oBUSY      = (r_state == LOAD) || (r_state == XFER) ||
                        (r_state == CHECK) || (r_state == NEXT);
    assign oDONE      = r_done;
    assign oERROR     = r_error;
    assign oERR_INDEX = r_errIdx;

endmodule
`default_nettype wire
